// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO feeding a UART transmitter: buffers system writes and presents one
// byte at a time on tx_data/tx_enable, advancing on each tx_done pulse.
module uart_tx_fifo_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          tx_done,
  input  logic          ovf_clr,
  output logic [7:0]    tx_data,
  output logic          tx_enable,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [15:0]   sent_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          pop, push, drop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a write into a full FIFO is kept
  // when the transmitter is also taking a byte.
  always_comb begin
    pop  = !empty && ((state == IDLE) || tx_done);
    push = wr_en && (!full || pop);
    drop = wr_en && full && !pop;
  end

  // NOTE: storage array is deliberately not reset; only pointers and count
  // define which entries are valid, and a reset-free array maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, e.g. tx_data reads mem[rp] before rp moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      tx_data   <= 8'h00;
      tx_enable <= 1'b0;
      overflow  <= 1'b0;
      sent_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_enable <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (tx_done) begin
            sent_cnt <= sent_cnt + 16'd1;
            if (!pop) begin
              tx_enable <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        tx_data <= mem[rp];
        rp      <= rp + 1'b1;
      end
      if (push) wp <= wp + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Randomised scoreboard bench for uart_tx_fifo_feeder against a queue-based
// model of the byte stream, occupancy, overflow and frame counting.
module tb_uart_tx_fifo_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          tx_done = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_enable;
  logic          full, empty;
  logic [AW:0]   count;
  logic          overflow;
  logic [15:0]   sent_cnt;

  uart_tx_fifo_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .tx_done(tx_done), .ovf_clr(ovf_clr), .tx_data(tx_data),
    .tx_enable(tx_enable), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes waiting, whether a frame is in flight, flags.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  bit         m_busy = 0;
  bit         m_ovf  = 0;
  int         m_sent = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_busy = 0;
    m_ovf  = 0;
    m_sent = 0;
  endtask

  task automatic model_step(input bit wr, input logic [7:0] d, input bit done, input bit clr);
    bit take, was_full;
    was_full = (m_q.size() == DEPTH);
    take = (m_q.size() > 0) && (!m_busy || done);
    if (m_busy && done) begin
      m_sent = (m_sent + 1) % 65536;
      if (!take) m_busy = 0;
    end
    if (take) begin
      void'(m_q.pop_front());
      m_busy = 1;
    end
    if (wr && (!was_full || take)) begin
      m_q.push_back(d);
      exp_q.push_back(d);
    end
    if (wr && was_full && !take) m_ovf = 1;
    else if (clr)                m_ovf = 0;
  endtask

  task automatic cycle(input bit wr, input logic [7:0] d, input bit done, input bit clr);
    wr_en = wr; wr_data = d; tx_done = done; ovf_clr = clr;
    @(posedge clk);
    model_step(wr, d, done, clr);
    @(negedge clk);
    wr_en = 0; tx_done = 0; ovf_clr = 0;
    check("count",     32'(count),     32'(m_q.size()));
    check("empty",     32'(empty),     32'(m_q.size() == 0));
    check("full",      32'(full),      32'(m_q.size() == DEPTH));
    check("tx_enable", 32'(tx_enable), 32'(m_busy));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("sent_cnt",  32'(sent_cnt),  32'(m_sent));
  endtask

  task automatic drain();
    int n = 0;
    while ((m_busy || m_q.size() > 0) && n < 200) begin
      cycle(0, 8'h00, m_busy && ($urandom_range(0, 2) == 0), 0);
      n++;
    end
    check("drain_bound", 32'(m_busy || m_q.size() > 0), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: a new byte is presented when tx_enable rises or stays high
  // across an accepted tx_done; otherwise tx_data must not move.
  bit         done_q  = 0;
  bit         en_prev = 0;
  logic [7:0] held    = 8'h00;

  always @(posedge clk) done_q <= tx_done && tx_enable;

  always @(negedge clk) begin
    if (tx_enable && (!en_prev || done_q)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=%0h expected=none at %0t", tx_data, $time);
      end else begin
        check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      held = tx_data;
    end else if (tx_enable) begin
      check("tx_data_hold", 32'(tx_data), 32'(held));
    end
    en_prev = tx_enable;
  end

  initial begin
    int accepted;
    #12;
    check("rst_tx_enable", 32'(tx_enable), 32'd0);
    check("rst_tx_data",   32'(tx_data),   32'h00);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_full",      32'(full),      32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_sent_cnt",  32'(sent_cnt),  32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single byte with a slow transmitter.
    cycle(1, 8'hA5, 0, 0);
    cycle(0, 8'h00, 0, 0);
    check("a5_presented", 32'(tx_data), 32'hA5);
    repeat (48) cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 1, 0);
    check("a5_idle_after_done", 32'(tx_enable), 32'd0);

    // Back-to-back frames.
    cycle(1, 8'h55, 0, 0);
    cycle(1, 8'hAA, 0, 0);
    cycle(1, 8'h0F, 0, 0);
    for (int i = 0; i < 3; i++) begin
      repeat (4) cycle(0, 8'h00, 0, 0);
      cycle(0, 8'h00, 1, 0);
    end
    check("b2b_sent", 32'(sent_cnt), 32'd4);

    // Fill past capacity with the transmitter stalled.
    for (int i = 0; i < 18; i++) cycle(1, 8'(i), 0, 0);
    check("fill_full",     32'(full),     32'd1);
    check("fill_overflow", 32'(overflow), 32'd1);
    cycle(0, 8'h00, 0, 1);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Write into a full FIFO in the same cycle as a pop.
    cycle(1, 8'h7E, 1, 0);
    check("full_pop_count", 32'(count), 32'd16);
    drain();

    // Stream 40 bytes through the pointer wrap.
    accepted = 0;
    while (accepted < 40) begin
      if ($urandom_range(0, 1) == 1 && m_q.size() < DEPTH) begin
        cycle(1, 8'($urandom), m_busy && ($urandom_range(0, 3) == 0), 0);
        accepted++;
      end else begin
        cycle(0, 8'h00, m_busy && ($urandom_range(0, 3) == 0), 0);
      end
    end
    drain();
    check("wrap_empty", 32'(empty), 32'd1);

    // Unconstrained random traffic, including drops and clears.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0);
    drain();

    // Asynchronous reset mid-frame with five bytes queued.
    for (int i = 0; i < 6; i++) cycle(1, 8'(8'hC0 + i), 0, 0);
    check("pre_rst_count", 32'(count), 32'd5);
    rst = 1'b0;
    #1;
    check("midrst_tx_enable", 32'(tx_enable), 32'd0);
    check("midrst_count",     32'(count),     32'd0);
    check("midrst_empty",     32'(empty),     32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (5) cycle(0, 8'h00, 1, 0);
    check("post_rst_idle", 32'(tx_enable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
